// File: rtl/coin_vend_ctrl_pkg.sv
// Shared types and constants for the coin collector / vend controller.
// Coin codes, coin values, FSM states and 7-seg digit patterns.
package coin_vend_ctrl_pkg;

  typedef enum logic [1:0] {
    COIN_25  = 2'b00,
    COIN_50  = 2'b01,
    COIN_100 = 2'b10,
    COIN_BAD = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHANGE
  } state_t;

  // active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic int unsigned coin_value(
    input logic [1:0] c
  );
    int unsigned v;
    v = 0;
    case (c)
      COIN_25:  v = 25;
      COIN_50:  v = 50;
      COIN_100: v = 100;
      default:  v = 0;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] chg_sel(
    input int unsigned amt
  );
    logic [1:0] c;
    c = COIN_25;
    if (amt >= 100)
      c = COIN_100;
    else if (amt >= 50)
      c = COIN_50;
    return c;
  endfunction

endpackage

// File: rtl/coin_vend_ctrl_if.sv
// Coin acceptor / hopper / display bundle of the vend controller.
// master = acceptor side driving coins, slave = the controller.
interface coin_vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin;
  logic                vend_req;
  logic                cancel;
  logic                chg_ready;
  logic                done;
  logic                coin_rej;
  logic                chg_valid;
  logic [1:0]          chg_coin;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic [6:0]          seg_r;
  logic [6:0]          seg_t;
  logic [6:0]          seg_u;

  modport master (
    output coin_valid, coin, vend_req,
    output cancel, chg_ready,
    input  done, coin_rej, chg_valid,
    input  chg_coin, busy, credit,
    input  seg_r, seg_t, seg_u
  );

  modport slave (
    input  coin_valid, coin, vend_req,
    input  cancel, chg_ready,
    output done, coin_rej, chg_valid,
    output chg_coin, busy, credit,
    output seg_r, seg_t, seg_u
  );
endinterface

// File: rtl/coin_vend_ctrl_seg.sv
// BCD digit to active-low seven-segment pattern.
// Non-decimal codes blank the digit.
module sevenseg_dec
  import coin_vend_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin collector / vend controller with change hopper handshake
// and an R.PP credit display.
module coin_vend_ctrl
  import coin_vend_ctrl_pkg::*;
#(
  parameter int unsigned PRICE      = 100,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned CREDIT_W   = 8,
  parameter bit          AUTO_VEND  = 1'b1
) (
  input logic             clock,
  input logic             reset,
  coin_vend_ctrl_if.slave bus
);

  if ((PRICE % 25) != 0 || PRICE < 25 ||
      PRICE > MAX_CREDIT ||
      (MAX_CREDIT % 25) != 0 ||
      MAX_CREDIT > 999 ||
      MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_cfg
    $error("coin_vend_ctrl: bad price/credit config");
  end

  localparam logic [CREDIT_W:0] MAX_W =
    (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_W =
    CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] remain_q;
  logic                done_q;
  logic                rej_q;
  logic                chg_valid_q;
  logic [1:0]          chg_coin_q;
  logic                busy_q;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] vend_rem;
  logic [CREDIT_W-1:0] rem_left;
  logic                can_vend;
  logic                do_cancel;
  logic                coin_ok;

  assign coin_val = CREDIT_W'(coin_value(bus.coin));
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};
  assign vend_rem = credit_q - PRICE_W;
  assign rem_left = remain_q -
    CREDIT_W'(coin_value(chg_coin_q));

  assign can_vend  = (credit_q >= PRICE_W) &&
                     (AUTO_VEND || bus.vend_req);
  assign do_cancel = bus.cancel && (credit_q != '0);

  // A cancel request always outranks a coin, even with no credit.
  assign coin_ok = bus.coin_valid &&
                   (bus.coin != COIN_BAD) &&
                   !bus.cancel && !can_vend &&
                   (sum <= MAX_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      credit_q    <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_coin_q  <= COIN_25;
      busy_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          rej_q <= bus.coin_valid && !coin_ok;
          if (do_cancel) begin
            remain_q    <= credit_q;
            credit_q    <= '0;
            state       <= CHANGE;
            chg_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            chg_coin_q  <= chg_sel(32'(credit_q));
          end else if (can_vend) begin
            done_q   <= 1'b1;
            credit_q <= '0;
            remain_q <= vend_rem;
            if (vend_rem != '0) begin
              state       <= CHANGE;
              chg_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              chg_coin_q  <= chg_sel(32'(vend_rem));
            end else begin
              state <= IDLE;
            end
          end else if (coin_ok) begin
            credit_q <= sum[CREDIT_W-1:0];
            state    <= COLLECT;
          end
        end
        CHANGE: begin
          rej_q <= bus.coin_valid;
          if (bus.chg_ready) begin
            remain_q <= rem_left;
            if (rem_left == '0) begin
              state       <= IDLE;
              chg_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              chg_coin_q <= chg_sel(32'(rem_left));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.coin_rej  = rej_q;
  assign bus.chg_valid = chg_valid_q;
  assign bus.chg_coin  = chg_coin_q;
  assign bus.busy      = busy_q;
  assign bus.credit    = credit_q;

  logic [31:0] cv;
  logic [3:0]  d_r;
  logic [3:0]  d_t;
  logic [3:0]  d_u;

  assign cv  = 32'(credit_q);
  assign d_r = 4'(cv / 100);
  assign d_t = 4'((cv % 100) / 10);
  assign d_u = 4'(cv % 10);

  sevenseg_dec u_seg_r (.bcd(d_r), .seg(bus.seg_r));
  sevenseg_dec u_seg_t (.bcd(d_t), .seg(bus.seg_t));
  sevenseg_dec u_seg_u (.bcd(d_u), .seg(bus.seg_u));

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Bench for coin_vend_ctrl: auto-vend and request-vend instances
// driven by directed scenarios and random traffic vs. a paise model.
module tb_coin_vend_ctrl;

  localparam int PRICE = 100;
  localparam int MAXC  = 200;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  coin_vend_ctrl_if ia ();
  coin_vend_ctrl_if im ();

  coin_vend_ctrl #(
    .PRICE(PRICE), .MAX_CREDIT(MAXC),
    .CREDIT_W(8), .AUTO_VEND(1'b1)
  ) u_auto (.clock(clock), .reset(reset), .bus(ia));

  coin_vend_ctrl #(
    .PRICE(PRICE), .MAX_CREDIT(MAXC),
    .CREDIT_W(8), .AUTO_VEND(1'b0)
  ) u_man (.clock(clock), .reset(reset), .bus(im));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: credit in paise, change still owed in paise.
  int m_credit [2];
  int m_rem    [2];
  bit m_done   [2];
  bit m_rej    [2];

  function automatic int cval(input logic [1:0] c);
    case (c)
      2'b00:   return 25;
      2'b01:   return 50;
      2'b10:   return 100;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] best(input int r);
    if (r >= 100) return 2'b10;
    if (r >= 50) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] digit(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100,
          7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000,
          7'b0010000};
    return t[d];
  endfunction

  task automatic model_edge(
    input int i, input logic cv,
    input logic [1:0] c, input logic vr,
    input logic cn, input logic rdy
  );
    int v;
    v = cval(c);
    m_done[i] = 0;
    m_rej[i]  = 0;
    if (reset) begin
      m_credit[i] = 0;
      m_rem[i]    = 0;
    end else if (m_rem[i] > 0) begin
      m_rej[i] = cv;
      if (rdy) m_rem[i] -= cval(best(m_rem[i]));
    end else if (cn && m_credit[i] > 0) begin
      m_rem[i]    = m_credit[i];
      m_credit[i] = 0;
      m_rej[i]    = cv;
    end else if (m_credit[i] >= PRICE &&
                 (i == 0 || vr)) begin
      m_done[i]   = 1;
      m_rem[i]    = m_credit[i] - PRICE;
      m_credit[i] = 0;
      m_rej[i]    = cv;
    end else if (cv) begin
      if (c != 2'b11 && !cn &&
          m_credit[i] + v <= MAXC)
        m_credit[i] += v;
      else
        m_rej[i] = 1;
    end
  endtask

  // {done,rej,valid,busy,coin,credit,seg_r,seg_t,seg_u}
  function automatic logic [34:0] expv(input int i);
    int c;
    bit a;
    c = m_credit[i];
    a = m_rem[i] > 0;
    return {m_done[i], m_rej[i], a, a,
            a ? best(m_rem[i]) : 2'b00, 8'(c),
            digit(c / 100), digit((c % 100) / 10),
            digit(c % 10)};
  endfunction

  function automatic logic [34:0] obsv(
    input int i, input bit mask
  );
    logic [1:0] cc;
    if (i == 0) begin
      cc = (mask && !ia.chg_valid) ? 2'b00 : ia.chg_coin;
      return {ia.done, ia.coin_rej, ia.chg_valid,
              ia.busy, cc, ia.credit,
              ia.seg_r, ia.seg_t, ia.seg_u};
    end
    cc = (mask && !im.chg_valid) ? 2'b00 : im.chg_coin;
    return {im.done, im.coin_rej, im.chg_valid,
            im.busy, cc, im.credit,
            im.seg_r, im.seg_t, im.seg_u};
  endfunction

  task automatic step();
    model_edge(0, ia.coin_valid, ia.coin,
               ia.vend_req, ia.cancel, ia.chg_ready);
    model_edge(1, im.coin_valid, im.coin,
               im.vend_req, im.cancel, im.chg_ready);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ia.coin_valid = 0; ia.coin = 0; ia.vend_req = 0;
    ia.cancel = 0; ia.chg_ready = 0;
    im.coin_valid = 0; im.coin = 0; im.vend_req = 0;
    im.cancel = 0; im.chg_ready = 0;
  endtask

  task automatic m_coin(input logic [1:0] c);
    im.coin_valid = 1;
    im.coin = c;
    step();
    im.coin_valid = 0;
  endtask

  task automatic test_reset();
    logic [34:0] z;
    z = {6'b0, 8'd0, 7'b1000000, 7'b1000000, 7'b1000000};
    idle_inputs();
    reset = 1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obsv(i, 0) !== z) begin
        errors++;
        $display("FAIL reset dut%0d got %h want %h",
                 i, obsv(i, 0), z);
      end
    end
    reset = 0;
    step();
  endtask

  task automatic test_auto_vend();
    for (int k = 1; k <= 4; k++) begin
      ia.coin_valid = 1;
      ia.coin = 2'b00;
      step();
      checks++;
      if (ia.credit !== 8'(25 * k) || ia.done !== 0) begin
        errors++;
        $display("FAIL auto_coin%0d got %0d/%b want %0d/0",
                 k, ia.credit, ia.done, 25 * k);
      end
    end
    // Coin offered during the vend cycle must bounce.
    ia.coin = 2'b01;
    step();
    ia.coin_valid = 0;
    checks++;
    if ({ia.done, ia.coin_rej, ia.credit} !==
        {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL auto_vend got d%b r%b c%0d want d1 r1 c0",
               ia.done, ia.coin_rej, ia.credit);
    end
    step();
    checks++;
    if ({ia.done, ia.chg_valid, ia.busy, ia.credit} !==
        {3'b000, 8'd0}) begin
      errors++;
      $display("FAIL auto_after got d%b v%b b%b c%0d want 0",
               ia.done, ia.chg_valid, ia.busy, ia.credit);
    end
  endtask

  task automatic test_manual_vend();
    m_coin(2'b00);
    m_coin(2'b01);
    m_coin(2'b01);
    checks++;
    if ({im.credit, im.seg_r, im.seg_t, im.seg_u, im.done} !==
        {8'd125, 7'b1111001, 7'b0100100, 7'b0010010, 1'b0}) begin
      errors++;
      $display("FAIL man_125 got c%0d %b %b %b d%b want 125 1 2 5",
               im.credit, im.seg_r, im.seg_t, im.seg_u, im.done);
    end
    im.vend_req = 1;
    step();
    im.vend_req = 0;
    checks++;
    if ({im.done, im.credit, im.chg_valid, im.chg_coin} !==
        {1'b1, 8'd0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL man_vend got d%b c%0d v%b coin%b want 1 0 1 00",
               im.done, im.credit, im.chg_valid, im.chg_coin);
    end
    im.chg_ready = 1;
    step();
    im.chg_ready = 0;
    checks++;
    if ({im.done, im.chg_valid, im.busy, im.credit} !==
        {3'b000, 8'd0}) begin
      errors++;
      $display("FAIL man_chg_end got d%b v%b b%b c%0d want 0",
               im.done, im.chg_valid, im.busy, im.credit);
    end
  endtask

  task automatic test_cancel_hold();
    m_coin(2'b00);
    m_coin(2'b01);
    im.cancel = 1;
    step();
    im.cancel = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({im.chg_valid, im.busy, im.chg_coin} !==
          {2'b11, 2'b01}) begin
        errors++;
        $display("FAIL hold%0d got v%b b%b coin%b want 1 1 01",
                 k, im.chg_valid, im.busy, im.chg_coin);
      end
      step();
    end
    im.chg_ready = 1;
    step();
    checks++;
    if ({im.chg_valid, im.chg_coin} !== 3'b100) begin
      errors++;
      $display("FAIL cancel_2nd got v%b coin%b want 1 00",
               im.chg_valid, im.chg_coin);
    end
    step();
    im.chg_ready = 0;
    checks++;
    if ({im.chg_valid, im.busy} !== 2'b00) begin
      errors++;
      $display("FAIL cancel_end got v%b b%b want 0 0",
               im.chg_valid, im.busy);
    end
  endtask

  task automatic test_ceiling();
    m_coin(2'b10);
    m_coin(2'b10);
    m_coin(2'b00);
    checks++;
    if ({im.coin_rej, im.credit} !== {1'b1, 8'd200}) begin
      errors++;
      $display("FAIL ceiling got r%b c%0d want 1 200",
               im.coin_rej, im.credit);
    end
    m_coin(2'b11);
    checks++;
    if ({im.coin_rej, im.credit} !== {1'b1, 8'd200}) begin
      errors++;
      $display("FAIL bad_code got r%b c%0d want 1 200",
               im.coin_rej, im.credit);
    end
    im.cancel = 1;
    m_coin(2'b00);
    im.cancel = 0;
    checks++;
    if ({im.coin_rej, im.credit, im.chg_valid, im.chg_coin} !==
        {1'b1, 8'd0, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL cancel_coin got r%b c%0d v%b coin%b want 1 0 1 10",
               im.coin_rej, im.credit, im.chg_valid, im.chg_coin);
    end
    im.chg_ready = 1;
    m_coin(2'b01);
    checks++;
    if ({im.coin_rej, im.chg_valid, im.chg_coin, im.credit} !==
        {2'b11, 2'b10, 8'd0}) begin
      errors++;
      $display("FAIL refund_2nd got r%b v%b coin%b c%0d want 1 1 10 0",
               im.coin_rej, im.chg_valid, im.chg_coin, im.credit);
    end
    step();
    im.chg_ready = 0;
    checks++;
    if ({im.chg_valid, im.busy} !== 2'b00) begin
      errors++;
      $display("FAIL refund_end got v%b b%b want 0 0",
               im.chg_valid, im.busy);
    end
  endtask

  task automatic test_reset_mid_change();
    logic [34:0] z;
    z = {6'b0, 8'd0, 7'b1000000, 7'b1000000, 7'b1000000};
    m_coin(2'b10);
    m_coin(2'b01);
    im.cancel = 1;
    step();
    im.cancel = 0;
    checks++;
    if ({im.chg_valid, im.chg_coin} !== 3'b110) begin
      errors++;
      $display("FAIL pre_reset got v%b coin%b want 1 10",
               im.chg_valid, im.chg_coin);
    end
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (obsv(1, 0) !== z) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", obsv(1, 0), z);
    end
    step();
    step();
    checks++;
    if ({im.chg_valid, im.busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset got v%b b%b want 0 0",
               im.chg_valid, im.busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      ia.coin_valid = $urandom_range(0, 1);
      ia.coin       = 2'($urandom_range(0, 3));
      ia.vend_req   = ($urandom_range(0, 3) == 0);
      ia.cancel     = ($urandom_range(0, 15) == 0);
      ia.chg_ready  = $urandom_range(0, 1);
      im.coin_valid = $urandom_range(0, 1);
      im.coin       = 2'($urandom_range(0, 3));
      im.vend_req   = ($urandom_range(0, 5) == 0);
      im.cancel     = ($urandom_range(0, 15) == 0);
      im.chg_ready  = $urandom_range(0, 1);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obsv(i, 1) !== expv(i)) begin
          errors++;
          $display("FAIL rand%0d dut%0d got %h want %h",
                   n, i, obsv(i, 1), expv(i));
        end
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1;
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0;
      m_rem[i]    = 0;
      m_done[i]   = 0;
      m_rej[i]    = 0;
    end
    test_reset();
    test_auto_vend();
    test_manual_vend();
    test_cancel_hold();
    test_ceiling();
    test_reset_mid_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
